// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_pkg
// Function : Shared types and constants for the RV32I fetch front end.
// Revision : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/ifetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_fifo
// Function : Small synchronous FIFO with flush; DEPTH must be a power of two.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= r_count + c_cnt_w'(push) - c_cnt_w'(pop);
        end
    end

    // Storage needs no reset: occupancy is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/ifetch.sv
`default_nettype none
// ============================================================================
// Module   : ifetch
// Function : Credit-based instruction fetch with redirect flush and response
//            drop. Optional misaligned-redirect halt: IFETCH_MISALIGN_CHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        misalign_err
);
    localparam int                 c_cnt_w      = $clog2(QDEPTH + 1);
    localparam logic [c_cnt_w:0]   c_credit_max = (c_cnt_w + 1)'(QDEPTH);

    fetch_state_t       w_state;
    logic [31:0]        r_fetch_pc;
    logic [c_cnt_w-1:0] r_outstanding;
    logic [c_cnt_w-1:0] r_drop;
    logic [c_cnt_w-1:0] w_q_count;
    logic [c_cnt_w:0]   w_inflight;
    logic [c_cnt_w-1:0] w_rsp_cnt;
    logic               w_q_empty;
    fetch_entry_t       w_q_head;
    fetch_entry_t       w_q_push_data;
    logic [31:0]        w_tag_head;
    logic [31:0]        w_redirect_pc;
    logic               w_accept;
    logic               w_drop_active;
    logic               w_rsp_keep;
    logic               w_pop;
    logic [c_cnt_w-1:0] w_unused_tag_count;
    logic               w_unused_tag_empty;

    // Every in-flight request has a reserved queue slot, so the queue never overflows.
    assign w_inflight     = {1'b0, r_outstanding} + {1'b0, w_q_count};
    assign imem_req_valid = rst_n && (w_state == RUN) && !redirect_valid
                            && (w_inflight < c_credit_max);
    assign imem_req_addr  = r_fetch_pc;

    assign w_accept      = imem_req_valid && imem_req_ready;
    assign w_rsp_cnt     = c_cnt_w'(imem_rsp_valid);
    assign w_drop_active = (r_drop != '0);
    assign w_rsp_keep    = imem_rsp_valid && !w_drop_active && !redirect_valid;
    assign w_pop         = out_valid && out_ready;

    assign out_valid = !w_q_empty && !redirect_valid;
    assign out_inst  = w_q_empty ? '0 : w_q_head.inst;
    assign out_pc    = w_q_empty ? '0 : w_q_head.pc;

    assign w_q_push_data = '{pc: w_tag_head, inst: imem_rsp_data};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else if (redirect_valid) begin
            // A response arriving with the redirect is discarded here, so it leaves the drop count.
            r_fetch_pc    <= w_redirect_pc;
            r_outstanding <= r_outstanding - w_rsp_cnt;
            r_drop        <= r_outstanding - w_rsp_cnt;
        end else begin
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            r_outstanding <= r_outstanding + c_cnt_w'(w_accept) - w_rsp_cnt;
            if (imem_rsp_valid && w_drop_active) begin
                r_drop <= r_drop - c_cnt_w'(1);
            end
        end
    end

`ifdef IFETCH_MISALIGN_CHK_EN
    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic         r_misalign_err;
    logic         w_misaligned;

    assign w_misaligned  = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign w_redirect_pc = redirect_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= RUN;
            r_misalign_err <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_misalign_err <= w_misaligned;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (redirect_valid) begin
            w_state_next = w_misaligned ? HALT : RUN;
        end
    end

    assign w_state      = r_state;
    assign misalign_err = r_misalign_err;
`else
    logic w_unused_pc_lsb;

    assign w_unused_pc_lsb = ^redirect_pc[1:0];
    assign w_redirect_pc   = {redirect_pc[31:2], 2'b00};
    assign w_state         = RUN;
    assign misalign_err    = 1'b0;
`endif

    ifetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (w_rsp_keep),
        .push_data (w_q_push_data),
        .pop       (w_pop),
        .head      (w_q_head),
        .empty     (w_q_empty),
        .count     (w_q_count)
    );

    ifetch_fifo #(
        .WIDTH (32),
        .DEPTH (QDEPTH)
    ) u_pc_tags (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (w_accept),
        .push_data (r_fetch_pc),
        .pop       (w_rsp_keep),
        .head      (w_tag_head),
        .empty     (w_unused_tag_empty),
        .count     (w_unused_tag_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_ifetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch
// Function : Self-checking bench for ifetch: vector table, directed corner
//            sequences and randomized traffic against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch;
    localparam int          c_qdepth = 2;
    localparam logic [31:0] c_rst_pc = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        misalign_err;

    ifetch #(
        .RESET_PC (c_rst_pc),
        .QDEPTH   (c_qdepth)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct packed {
        logic        rdy;
        logic        ordy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [31:0] e_opc;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural view of the fetch unit plus the memory.
    logic [31:0] m_pc;
    int          m_out;
    int          m_drop;
    logic        m_halt;
    logic        m_mis;
    ent_t        m_q[$];
    logic [31:0] m_tags[$];
    logic [31:0] mem_q[$];

    logic        s_req_valid;
    logic [31:0] s_req_addr;
    logic        s_out_valid;
    logic [31:0] s_out_inst;
    logic [31:0] s_out_pc;
    logic        s_mis;

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic rst_v, input logic rdy, input logic ordy,
                         input logic rsp_en, input logic redir, input logic [31:0] rpc);
        logic        rsp;
        logic        acc;
        logic        e_req;
        logic        e_ov;
        logic        mis;
        logic [31:0] e_opc;
        logic [31:0] e_oinst;
        logic [31:0] tgt;
        logic [31:0] rdata;
        logic [31:0] tag;
        @(negedge clk);
        rsp   = rsp_en && rst_v && (mem_q.size() > 0);
        rdata = rsp ? hash(mem_q[0]) : $urandom;
        rst_n          = rst_v;
        imem_req_ready = rdy;
        out_ready      = ordy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rdata;

        e_req   = rst_v && !m_halt && !redir && ((m_out + m_q.size()) < c_qdepth);
        e_ov    = (m_q.size() > 0) && !redir;
        e_opc   = (m_q.size() > 0) ? m_q[0].pc : 32'h0;
        e_oinst = (m_q.size() > 0) ? m_q[0].inst : 32'h0;

        #2;
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_out_valid = out_valid;
        s_out_inst  = out_inst;
        s_out_pc    = out_pc;
        s_mis       = misalign_err;
        check("req_valid", {31'h0, s_req_valid}, {31'h0, e_req});
        check("req_addr", s_req_addr, m_pc);
        check("out_valid", {31'h0, s_out_valid}, {31'h0, e_ov});
        check("out_pc", s_out_pc, e_opc);
        check("out_inst", s_out_inst, e_oinst);
        check("misalign_err", {31'h0, s_mis}, {31'h0, m_mis});

`ifdef IFETCH_MISALIGN_CHK_EN
        mis = (rpc[1:0] != 2'b00);
        tgt = rpc;
`else
        mis = 1'b0;
        tgt = rpc & 32'hFFFF_FFFC;
`endif
        acc = e_req && rdy;
        if (!rst_v) begin
            m_pc = c_rst_pc; m_out = 0; m_drop = 0; m_halt = 1'b0; m_mis = 1'b0;
            m_q.delete(); m_tags.delete(); mem_q.delete();
        end else begin
            if (rsp) mem_q.delete(0);
            if (acc) mem_q.push_back(m_pc);
            if (redir) begin
                m_drop = m_out - (rsp ? 1 : 0);
                m_out  = m_drop;
                m_q.delete();
                m_tags.delete();
                m_pc   = tgt;
                m_halt = mis;
                m_mis  = mis;
            end else begin
                m_mis = 1'b0;
                if (e_ov && ordy) m_q.delete(0);
                if (acc) begin
                    m_tags.push_back(m_pc);
                    m_pc  = m_pc + 32'd4;
                    m_out = m_out + 1;
                end
                if (rsp) begin
                    m_out = m_out - 1;
                    if (m_drop > 0) begin
                        m_drop = m_drop - 1;
                    end else begin
                        tag = (m_tags.size() > 0) ? m_tags.pop_front() : 32'hDEAD_DEAD;
                        m_q.push_back('{pc: tag, inst: rdata});
                    end
                end
            end
        end
    endtask

    task automatic drain();
        repeat (6) cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[7];
        int          n_req;
        logic        seen;
        logic [31:0] hold;
        logic        found;
        logic        rst_v;
        logic        redir;
        logic [31:0] rpc;

        rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        m_pc = c_rst_pc; m_out = 0; m_drop = 0; m_halt = 1'b0; m_mis = 1'b0;

        vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h08, 1'b1, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h4};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h8};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC};

        repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("rst_req_valid", {31'h0, s_req_valid}, 32'h0);
        check("rst_out_valid", {31'h0, s_out_valid}, 32'h0);

        // Single-cycle memory after reset
        foreach (vecs[i]) begin
            cycle(1'b1, vecs[i].rdy, vecs[i].ordy, 1'b1, 1'b0, 32'h0);
            check("vec_req_valid", {31'h0, s_req_valid}, {31'h0, vecs[i].e_req});
            check("vec_req_addr", s_req_addr, vecs[i].e_addr);
            check("vec_out_valid", {31'h0, s_out_valid}, {31'h0, vecs[i].e_ov});
            check("vec_out_pc", s_out_pc, vecs[i].e_opc);
            check("vec_out_inst", s_out_inst, vecs[i].e_ov ? hash(vecs[i].e_opc) : 32'h0);
        end

        // Decode stall: credits cap issue at the queue depth
        drain();
        n_req = 0; seen = 1'b0; hold = '0;
        repeat (10) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
            if (s_req_valid) n_req++;
            if (seen) begin
                check("stall_out_valid", {31'h0, s_out_valid}, 32'h1);
                check("stall_out_inst", s_out_inst, hold);
            end else if (s_out_valid) begin
                seen = 1'b1;
                hold = s_out_inst;
            end
        end
        check("stall_req_count", n_req, c_qdepth);
        repeat (6) cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect with two requests outstanding
        drain();
        n_req = 0;
        repeat (2) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            if (s_req_valid) n_req++;
        end
        check("redir_outstanding", n_req, 2);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            if (s_out_valid) begin
                found = 1'b1;
                check("redir_first_pc", s_out_pc, 32'h100);
            end
        end
        if (!found) check("redir_first_timeout", 32'h0, 32'h1);

        // Redirect colliding with an output handshake and a response
        drain();
        repeat (2) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h300);
        check("collide_out_valid", {31'h0, s_out_valid}, 32'h0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            if (s_req_valid) begin
                found = 1'b1;
                check("collide_next_addr", s_req_addr, 32'h300);
            end
        end
        if (!found) check("collide_req_timeout", 32'h0, 32'h1);

        // Misaligned redirect target
        drain();
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h102);
`ifdef IFETCH_MISALIGN_CHK_EN
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("mis_pulse", {31'h0, s_mis}, 32'h1);
        check("mis_halt_req", {31'h0, s_req_valid}, 32'h0);
        repeat (5) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            check("mis_pulse_end", {31'h0, s_mis}, 32'h0);
            check("mis_halt_req", {31'h0, s_req_valid}, 32'h0);
        end
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("mis_resume_valid", {31'h0, s_req_valid}, 32'h1);
        check("mis_resume_addr", s_req_addr, 32'h200);
`else
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("align_mis", {31'h0, s_mis}, 32'h0);
        check("align_req_valid", {31'h0, s_req_valid}, 32'h1);
        check("align_req_addr", s_req_addr, 32'h100);
`endif

        // Reset in the middle of traffic
        repeat (3) cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("midrst_req_valid", {31'h0, s_req_valid}, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("midrst_addr", s_req_addr, c_rst_pc);
        check("midrst_req_valid_after", {31'h0, s_req_valid}, 32'h1);
        check("midrst_out_valid", {31'h0, s_out_valid}, 32'h0);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            rst_v = ($urandom_range(0, 199) != 0);
            redir = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       rpc = 32'hFFFF_FFF8;
                default: rpc = 32'($urandom_range(0, 4095)) & 32'hFFFF_FFFC;
            endcase
            if ($urandom_range(0, 5) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            cycle(rst_v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), redir, rpc);
            if (s_out_valid) check("rand_inst_vs_pc", s_out_inst, hash(s_out_pc));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter QDEPTH, default 2, meaning fetch queue entries; legal values 2 and 4.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts the request.
REQ-007 SHALL have port imem_req_addr  output  32  word-aligned fetch address.
REQ-008 SHALL have port imem_rsp_valid  input  1  in-order instruction word return.
REQ-009 SHALL have port imem_rsp_data  input  32  returned instruction word.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump target from execute.
REQ-011 SHALL have port redirect_pc  input  32  new fetch PC.
REQ-012 SHALL have port out_valid  output  1  instruction available to decode/immgen.
REQ-013 SHALL have port out_ready  input  1  decode consumes the instruction.
REQ-014 SHALL have port out_inst  output  32  instruction word; bits [31:7] feed immgen.
REQ-015 SHALL have port out_pc  output  32  PC of out_inst.
REQ-016 SHALL have port misalign_err  output  1  misaligned redirect flag; tied 0 when the feature is compiled out.

Function
REQ-017 SHALL keep fetch_pc; issue imem_req_valid when (outstanding + queue count) < QDEPTH and state is RUN; imem_req_addr = fetch_pc.
REQ-018 SHALL, on imem_req_valid && imem_req_ready, increment fetch_pc by 4 (wraps 32'hFFFF_FFFC -> 0) and increment outstanding.
REQ-019 SHALL, on imem_rsp_valid with drop count 0, push {pc, data} into the queue; tag pc from an internal in-order PC FIFO of issued addresses.
REQ-020 SHALL drive out_valid = queue non-empty && !redirect_valid; out_inst/out_pc = queue head, zero when empty.
REQ-021 SHALL pop the queue on out_valid && out_ready; push and pop in the same cycle keep the count unchanged.
REQ-022 SHALL, on redirect_valid, flush the queue, set fetch_pc = redirect_pc, load drop count = outstanding requests (including any accepted that cycle); no imem request issued in the redirect cycle.
REQ-023 SHALL discard responses while drop count > 0, decrementing per response; discarded words never reach out_*.
REQ-024 SHALL never overflow the queue: the credit rule in REQ-017 guarantees room for every outstanding response.
REQ-025 SHALL give redirect priority over every other same-cycle event (response, pop, request acceptance).
REQ-026 SHALL hold outputs stable while out_valid && !out_ready.

Reset
REQ-027 SHALL, while rst_n low at a clock edge: fetch_pc = RESET_PC, queue empty, outstanding = 0, drop count = 0, state RUN, imem_req_valid = 0, out_valid = 0, misalign_err = 0.
REQ-028 SHALL issue the first request in the first cycle after rst_n deasserts; the memory shares rst_n, so no pre-reset responses arrive.

Configuration
REQ-029 SHALL, with IFETCH_MISALIGN_CHK_EN defined, on redirect with redirect_pc[1:0] != 0: pulse misalign_err for one cycle, flush as in REQ-022, enter HALT (no requests) until an aligned redirect returns it to RUN.
REQ-030 SHALL, without IFETCH_MISALIGN_CHK_EN, force redirect_pc[1:0] to 2'b00, have no HALT state, and tie misalign_err to 0.

Structure
REQ-031 SHALL place RESET_PC default, the state enum {RUN, HALT}, and the fetch-entry struct {pc, inst} in the shared package rv32i_pkg.
REQ-032 SHALL implement the queue and the PC tag FIFO as instances of one sub-module, ifetch_fifo (parameterised width/depth, synchronous active-low reset).

Verification
REQ-033 SHALL cover reset then 1-cycle memory with out_ready = 1: addresses 0x0, 0x4, 0x8 in order; out_pc follows with correct out_inst.
REQ-034 SHALL cover out_ready = 0 for 10 cycles: exactly QDEPTH requests issued, then none; out_inst stable; correct resumption on release.
REQ-035 SHALL cover redirect to 0x100 with 2 requests outstanding: both responses dropped; first out_pc = 0x100.
REQ-036 SHALL cover redirect in the same cycle as out handshake and response: queue flushed, out_valid = 0 that cycle, next request addresses redirect_pc.
REQ-037 SHALL cover redirect_pc = 0x102: with macro, misalign_err for 1 cycle and no requests until redirect 0x200; without macro, fetch from 0x100.
REQ-038 SHALL cover rst_n low mid-stream: next cycle imem_req_addr = RESET_PC, out_valid = 0.
